// File: rtl/corr_pkg.sv
// Shared definitions for the correlator peak detector: register offsets,
// event record layout, FSM states and the magnitude helper.
package corr_pkg;

  localparam logic [31:0] OFF_CTRL       = 32'h00;
  localparam logic [31:0] OFF_WINDOW     = 32'h04;
  localparam logic [31:0] OFF_TH_LO      = 32'h08;
  localparam logic [31:0] OFF_TH_HI      = 32'h0C;
  localparam logic [31:0] OFF_STATUS     = 32'h10;
  localparam logic [31:0] OFF_EVT_ID     = 32'h14;
  localparam logic [31:0] OFF_EVT_CNT    = 32'h18;
  localparam logic [31:0] OFF_EVT_MAG_LO = 32'h1C;
  localparam logic [31:0] OFF_EVT_MAG_HI = 32'h20;
  localparam logic [31:0] OFF_EVT_POP    = 32'h24;

  // Widest correlator index an event record can carry.
  localparam int ID_MAX = 8;

  localparam logic [63:0] MAG_SAT = 64'h7FFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {IDLE, ACCUM, COMMIT} state_t;

  typedef struct packed {
    logic [ID_MAX-1:0] id;
    logic [31:0]       cnt;
    logic [63:0]       mag;
  } evt_t;

  // |v| as unsigned; the most negative value has no positive twin, so clamp it.
  function automatic logic [63:0] abs_sat(input logic [63:0] v);
    if (!v[63])
      return v;
    if (v == 64'h8000_0000_0000_0000)
      return MAG_SAT;
    return 64'd0 - v;
  endfunction

endpackage

// File: rtl/corr_evt_fifo.sv
// Synchronous event FIFO with occupancy count; simultaneous push and pop are
// both honoured, including when full. Reports a drop pulse on a rejected push.
module corr_evt_fifo #(
  parameter int W     = 104,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage has no reset; validity is tracked by the pointers and count,
  // which keeps the array as plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/corr_peak_detect.sv
// Tracks the largest correlator dump magnitude over a programmable window and
// queues threshold-qualified peaks in a bus-readable event FIFO.
module corr_peak_detect
  import corr_pkg::*;
#(
  parameter logic [31:0] BASE  = 32'hFE000900,
  parameter int          DEPTH = 8,
  parameter int          IDW   = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    addr,
  input  logic [31:0]    Wdata,
  input  logic           write,
  input  logic           read,
  output logic [31:0]    Rdata,
  input  logic           dump_valid,
  input  logic [63:0]    dump_value,
  input  logic [31:0]    dump_cnt,
  input  logic [IDW-1:0] dump_id,
  output logic           irq
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic        ctrl_en, ctrl_irq_en, overflow;
  logic [31:0] window, th_lo, th_hi;

  state_t      state, state_next;
  logic [31:0] wcnt, wcnt_next, win_eff;
  evt_t        s1, peak, peak_next;
  logic        s1_valid, push;

  evt_t        head, fifo_dout;
  logic [CW-1:0] fifo_count;
  logic        fifo_full, fifo_empty, fifo_drop;

  logic [31:0] off;
  logic        wr_ctrl, pop;

  assign off     = addr - BASE;
  assign wr_ctrl = write && (off == OFF_CTRL);
  assign pop     = write && (off == OFF_EVT_POP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      window      <= '0;
      th_lo       <= '0;
      th_hi       <= '0;
      overflow    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en     <= Wdata[0];
        ctrl_irq_en <= Wdata[1];
      end
      if (write && off == OFF_WINDOW) window <= Wdata;
      if (write && off == OFF_TH_LO)  th_lo  <= Wdata;
      if (write && off == OFF_TH_HI)  th_hi  <= Wdata;
      // A fresh overflow beats a simultaneous clear request.
      if (fifo_drop)                 overflow <= 1'b1;
      else if (wr_ctrl && Wdata[2])  overflow <= 1'b0;
    end
  end

  // Stage 1: magnitude. A dump held during COMMIT is consumed on return to ACCUM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (!ctrl_en) begin
      s1_valid <= 1'b0;
    end else if (dump_valid && state != IDLE) begin
      s1_valid <= 1'b1;
      s1.id    <= ID_MAX'(dump_id);
      s1.cnt   <= dump_cnt;
      s1.mag   <= abs_sat(dump_value);
    end else if (state == ACCUM) begin
      s1_valid <= 1'b0;
    end
  end

  assign win_eff = (window == '0) ? 32'd1 : window;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wcnt  <= '0;
      peak  <= '0;
    end else begin
      state <= state_next;
      wcnt  <= wcnt_next;
      peak  <= peak_next;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which is what would otherwise infer a latch.
  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    peak_next  = peak;
    push       = 1'b0;
    unique case (state)
      IDLE: begin
        wcnt_next = '0;
        peak_next = '0;
        if (ctrl_en) state_next = ACCUM;
      end
      ACCUM: begin
        if (!ctrl_en) begin
          state_next = IDLE;
          wcnt_next  = '0;
          peak_next  = '0;
        end else if (s1_valid) begin
          // Strict compare keeps the earliest dump on ties; first dump always loads.
          if (wcnt == '0 || s1.mag > peak.mag) peak_next = s1;
          wcnt_next = wcnt + 32'd1;
          if (wcnt_next >= win_eff) state_next = COMMIT;
        end
      end
      COMMIT: begin
        push       = (peak.mag >= {th_hi, th_lo});
        wcnt_next  = '0;
        peak_next  = '0;
        state_next = ctrl_en ? ACCUM : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  corr_evt_fifo #(.W($bits(evt_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (peak),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  assign head = fifo_empty ? '0 : fifo_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= ctrl_irq_en && !fifo_empty;
  end

  always_comb begin
    Rdata = '0;
    if (!rst && read) begin
      case (off)
        OFF_CTRL:       Rdata = {30'd0, ctrl_irq_en, ctrl_en};
        OFF_WINDOW:     Rdata = window;
        OFF_TH_LO:      Rdata = th_lo;
        OFF_TH_HI:      Rdata = th_hi;
        OFF_STATUS:     Rdata = {22'd0, state != IDLE, overflow, 8'(fifo_count)};
        OFF_EVT_ID:     Rdata = 32'(head.id);
        OFF_EVT_CNT:    Rdata = head.cnt;
        OFF_EVT_MAG_LO: Rdata = head.mag[31:0];
        OFF_EVT_MAG_HI: Rdata = head.mag[63:32];
        default:        Rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_corr_peak_detect.sv
// Directed bench for corr_peak_detect: windows, saturation, ties, FIFO
// overflow with simultaneous pop, enable drop and zero-length windows.
module tb_corr_peak_detect;
  import corr_pkg::*;

  localparam logic [31:0] BASE = 32'hFE000900;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, Wdata, Rdata;
  logic        write, read, irq;
  logic        dump_valid;
  logic [63:0] dump_value;
  logic [31:0] dump_cnt;
  logic [4:0]  dump_id;

  int n_cmp = 0;
  int n_bad = 0;

  corr_peak_detect #(.BASE(BASE), .DEPTH(8), .IDW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .Wdata      (Wdata),
    .write      (write),
    .read       (read),
    .Rdata      (Rdata),
    .dump_valid (dump_valid),
    .dump_value (dump_value),
    .dump_cnt   (dump_cnt),
    .dump_id    (dump_id),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] d);
    addr = BASE + off;
    read = 1'b1;
    #1;
    d    = Rdata;
    read = 1'b0;
  endtask

  task automatic expect_reg(input string tag, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] d;
    @(negedge clk);
    rd(off, d);
    check(tag, 64'(d), 64'(exp));
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    @(negedge clk);
    addr  = BASE + off;
    Wdata = d;
    write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic dump(input logic [63:0] v, input logic [31:0] c, input logic [4:0] id);
    @(negedge clk);
    dump_value = v;
    dump_cnt   = c;
    dump_id    = id;
    dump_valid = 1'b1;
    @(negedge clk);
    dump_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  initial begin
    logic [31:0] d;
    bit          seen;

    rst = 1'b1; addr = '0; Wdata = '0; write = 1'b0; read = 1'b0;
    dump_valid = 1'b0; dump_value = '0; dump_cnt = '0; dump_id = '0;

    repeat (2) @(negedge clk);
    rd(OFF_CTRL, d);
    check("rdata_in_reset", 64'(d), 64'd0);
    check("irq_in_reset", 64'(irq), 64'd0);
    rst = 1'b0;
    expect_reg("status_reset", OFF_STATUS, 32'h0);
    expect_reg("window_reset", OFF_WINDOW, 32'h0);
    expect_reg("evt_id_reset", OFF_EVT_ID, 32'h0);
    expect_reg("unmapped", 32'h40, 32'h0);

    // Basic window of 4: peak is the -1500 dump.
    wr(OFF_WINDOW, 32'd4);
    wr(OFF_TH_LO, 32'd1000);
    wr(OFF_TH_HI, 32'd0);
    wr(OFF_CTRL, 32'h3);
    repeat (2) @(negedge clk);
    dump(-64'sd500,  32'd100, 5'd1);
    dump(64'sd1200,  32'd200, 5'd2);
    dump(-64'sd1500, 32'd300, 5'd3);
    @(negedge clk);
    dump_value = 64'sd900; dump_cnt = 32'd400; dump_id = 5'd4; dump_valid = 1'b1;
    @(negedge clk);
    dump_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      rd(OFF_STATUS, d);
      if (d[7:0] != 8'd0) seen = 1'b1;
    end
    check("evt_seen", 64'(seen), 64'd1);
    check("irq_lags_count", 64'(irq), 64'd0);
    @(negedge clk);
    check("irq_after_push", 64'(irq), 64'd1);
    expect_reg("basic_status", OFF_STATUS, 32'h201);
    expect_reg("basic_id",     OFF_EVT_ID, 32'd3);
    expect_reg("basic_cnt",    OFF_EVT_CNT, 32'd300);
    expect_reg("basic_mag_lo", OFF_EVT_MAG_LO, 32'd1500);
    expect_reg("basic_mag_hi", OFF_EVT_MAG_HI, 32'd0);
    wr(OFF_EVT_POP, 32'd0);
    expect_reg("basic_popped", OFF_STATUS, 32'h200);
    @(negedge clk);
    check("irq_clear", 64'(irq), 64'd0);

    // Saturation of the most negative sum.
    wr(OFF_WINDOW, 32'd1);
    wr(OFF_TH_LO, 32'hFFFF_FFFF);
    wr(OFF_TH_HI, 32'hFFFF_FFFF);
    dump(64'h8000_0000_0000_0000, 32'd7, 5'd7);
    settle();
    expect_reg("sat_below_th", OFF_STATUS, 32'h200);
    wr(OFF_TH_HI, 32'h7FFF_FFFF);
    dump(64'h8000_0000_0000_0000, 32'd8, 5'd8);
    settle();
    expect_reg("sat_status", OFF_STATUS, 32'h201);
    expect_reg("sat_mag_hi", OFF_EVT_MAG_HI, 32'h7FFF_FFFF);
    expect_reg("sat_mag_lo", OFF_EVT_MAG_LO, 32'hFFFF_FFFF);
    wr(OFF_EVT_POP, 32'd0);

    // Tie: earliest dump wins.
    wr(OFF_WINDOW, 32'd2);
    wr(OFF_TH_HI, 32'd0);
    wr(OFF_TH_LO, 32'd1);
    dump(64'sd700,  32'd11, 5'd3);
    dump(-64'sd700, 32'd12, 5'd9);
    settle();
    expect_reg("tie_status", OFF_STATUS, 32'h201);
    expect_reg("tie_id", OFF_EVT_ID, 32'd3);
    wr(OFF_EVT_POP, 32'd0);

    // Overflow: nine one-dump windows into an 8-deep FIFO.
    wr(OFF_WINDOW, 32'd1);
    for (int i = 1; i <= 9; i++) dump(64'sd50, 32'(i), 5'(i));
    settle();
    expect_reg("ovf_status", OFF_STATUS, 32'h308);
    expect_reg("ovf_head", OFF_EVT_ID, 32'd1);
    // Tenth push lands in the COMMIT cycle together with a pop.
    @(negedge clk);
    dump_value = 64'sd50; dump_cnt = 32'd10; dump_id = 5'd10; dump_valid = 1'b1;
    @(negedge clk);
    dump_valid = 1'b0;
    @(negedge clk);
    addr = BASE + OFF_EVT_POP; Wdata = '0; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    settle();
    expect_reg("ovf_pushpop_status", OFF_STATUS, 32'h308);
    expect_reg("ovf_pushpop_head", OFF_EVT_ID, 32'd2);
    wr(OFF_CTRL, 32'h7);
    expect_reg("ovf_cleared", OFF_STATUS, 32'h208);
    expect_reg("ctrl_readback", OFF_CTRL, 32'h3);
    for (int i = 0; i < 8; i++) wr(OFF_EVT_POP, 32'd0);
    expect_reg("ovf_drained", OFF_STATUS, 32'h200);

    // Enable dropped mid-window: partial window discarded.
    wr(OFF_WINDOW, 32'd4);
    wr(OFF_TH_LO, 32'd1000);
    dump(64'sd5000, 32'd1, 5'd1);
    dump(64'sd6000, 32'd2, 5'd2);
    wr(OFF_CTRL, 32'h2);
    settle();
    expect_reg("disabled_status", OFF_STATUS, 32'h000);
    wr(OFF_CTRL, 32'h3);
    repeat (2) @(negedge clk);
    dump(64'sd100,  32'd21, 5'd11);
    dump(64'sd2000, 32'd22, 5'd12);
    dump(64'sd300,  32'd23, 5'd13);
    dump(64'sd400,  32'd24, 5'd14);
    settle();
    expect_reg("reenable_status", OFF_STATUS, 32'h201);
    expect_reg("reenable_id", OFF_EVT_ID, 32'd12);
    expect_reg("reenable_mag", OFF_EVT_MAG_LO, 32'd2000);
    wr(OFF_EVT_POP, 32'd0);

    // WINDOW=0 behaves as 1.
    wr(OFF_WINDOW, 32'd0);
    dump(64'sd1500, 32'd31, 5'd20);
    dump(64'sd10,   32'd32, 5'd21);
    dump(-64'sd3000, 32'd33, 5'd22);
    settle();
    expect_reg("w0_status", OFF_STATUS, 32'h202);
    expect_reg("w0_head0", OFF_EVT_ID, 32'd20);
    wr(OFF_EVT_POP, 32'd0);
    expect_reg("w0_head1", OFF_EVT_ID, 32'd22);
    expect_reg("w0_mag1", OFF_EVT_MAG_LO, 32'd3000);
    expect_reg("w0_cnt1", OFF_EVT_CNT, 32'd33);
    wr(OFF_EVT_POP, 32'd0);

    // Empty FIFO: head fields read 0, pop is harmless, irq low.
    expect_reg("empty_id", OFF_EVT_ID, 32'd0);
    expect_reg("empty_cnt", OFF_EVT_CNT, 32'd0);
    expect_reg("empty_mag_lo", OFF_EVT_MAG_LO, 32'd0);
    expect_reg("empty_mag_hi", OFF_EVT_MAG_HI, 32'd0);
    wr(OFF_EVT_POP, 32'd0);
    expect_reg("empty_pop_status", OFF_STATUS, 32'h200);
    @(negedge clk);
    check("empty_irq", 64'(irq), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
